// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, then
// shifts one command byte out on device-generated clock edges and samples the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       kb_negedge,
  input  logic       kb_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       kb_clk_oe,
  output logic       kb_data_oe,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err
);

  localparam int MAX_AB = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int MAX_CD = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST   = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INHIBIT = 3'd1;
  localparam logic [2:0] RTS     = 3'd2;
  localparam logic [2:0] SEND    = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [CNT_W-1:0] send_last;

  assign tx_ready  = (state == IDLE);
  assign tx_busy   = (state != IDLE);
  // The device gets a longer grace period to produce its very first clock edge.
  assign send_last = (bit_cnt == 4'd0) ? START_LAST : BIT_LAST;

  // Frame image: stop bit, odd parity, data LSB first.
  always_ff @(posedge sys_clk) begin
    if (tx_valid && tx_ready) shreg <= {1'b1, ~^tx_data, tx_data};
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      kb_clk_oe  <= 1'b0;
      kb_data_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_ack     <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          kb_clk_oe  <= 1'b0;
          kb_data_oe <= 1'b0;
          if (tx_valid) begin
            state     <= INHIBIT;
            cnt       <= '0;
            kb_clk_oe <= 1'b1;
            tx_ack    <= 1'b0;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            state      <= RTS;
            cnt        <= '0;
            kb_data_oe <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RTS: begin
          if (cnt == RTS_LAST) begin
            state     <= SEND;
            cnt       <= '0;
            bit_cnt   <= '0;
            kb_clk_oe <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SEND: begin
          // A clock edge always beats a watchdog expiry in the same cycle.
          if (kb_negedge) begin
            kb_data_oe <= ~shreg[bit_cnt];
            bit_cnt    <= bit_cnt + 4'd1;
            cnt        <= '0;
            if (bit_cnt == 4'd9) state <= ACK;
          end else if (cnt == send_last) begin
            state      <= IDLE;
            kb_clk_oe  <= 1'b0;
            kb_data_oe <= 1'b0;
            tx_err     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ACK: begin
          kb_data_oe <= 1'b0;
          if (kb_negedge) begin
            tx_ack  <= ~kb_data;
            tx_done <= 1'b1;
            state   <= DONE;
            cnt     <= '0;
          end else if (cnt == BIT_LAST) begin
            state  <= IDLE;
            tx_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state      <= IDLE;
          kb_clk_oe  <= 1'b0;
          kb_data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: a behavioural keyboard clocks frames, and a
// frame-level model predicts line levels, phase lengths, ACK and timeout timing.
module tb_ps2_host_tx;

  localparam int INH   = 8;
  localparam int RTSC  = 2;
  localparam int START = 300;
  localparam int BITT  = 120;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic       kb_negedge = 1'b0;
  logic       kb_data = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, kb_clk_oe, kb_data_oe, tx_done, tx_ack, tx_err;

  int errors = 0;
  int checks = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .START_TIMEOUT(START), .BIT_TIMEOUT(BITT)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .kb_negedge(kb_negedge), .kb_data(kb_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .kb_clk_oe(kb_clk_oe), .kb_data_oe(kb_data_oe), .tx_done(tx_done), .tx_ack(tx_ack),
    .tx_err(tx_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Line levels the device should see for bit positions 0..9 (data LSB first, odd parity, stop).
  function automatic logic [9:0] frame_levels(input logic [7:0] d);
    int ones = 0;
    logic [9:0] lv;
    for (int i = 0; i < 8; i++) begin
      lv[i] = d[i];
      if (d[i]) ones++;
    end
    lv[8] = (ones % 2 == 0);
    lv[9] = 1'b1;
    return lv;
  endfunction

  task automatic wait_err(input string tag, input int limit);
    int n = 0;
    bit saw_done = 0;
    while (!tx_err && n < limit + 20) begin
      tick();
      n++;
      if (tx_done) saw_done = 1;
    end
    tx_valid = 1'b0;
    chk({tag, "_err_cycles"}, n, limit);
    chk({tag, "_no_done"}, {31'd0, saw_done}, 0);
    chk({tag, "_oe_released"}, {30'd0, kb_clk_oe, kb_data_oe}, 0);
    chk({tag, "_ready"}, {31'd0, tx_ready}, 1);
    tick();
    chk({tag, "_err_pulse"}, {31'd0, tx_err}, 0);
    chk({tag, "_idle"}, {31'd0, tx_busy}, 0);
  endtask

  // mode: 0 ACK, 1 no ACK, 2 silent device, 3 device stalls after k edges, 4 reset after k edges
  task automatic run_frame(input logic [7:0] d, input int mode, input int k);
    logic [9:0] lv;
    int n;
    int edges;
    lv = frame_levels(d);
    tx_data  = d;
    tx_valid = 1'b1;
    chk("ready_before", {31'd0, tx_ready}, 1);
    tick();
    chk("ready_after_hs", {31'd0, tx_ready}, 0);
    chk("inhibit_entry", {30'd0, kb_clk_oe, kb_data_oe}, 2'b10);
    tx_data = 8'($urandom);
    n = 0;
    while (kb_clk_oe && !kb_data_oe && n < INH + 10) begin
      n++;
      kb_negedge = (n == 2);
      tick();
    end
    kb_negedge = 1'b0;
    chk("inhibit_len", n, INH);
    n = 0;
    while (kb_clk_oe && kb_data_oe && n < RTSC + 10) begin
      n++;
      tick();
    end
    chk("rts_len", n, RTSC);
    chk("start_bit", {30'd0, kb_clk_oe, kb_data_oe}, 2'b01);
    chk("busy_send", {31'd0, tx_busy}, 1);
    if (mode == 2) begin
      wait_err("start_to", START);
      return;
    end
    edges = (mode >= 3) ? k : 10;
    for (int i = 0; i < edges; i++) begin
      logic hold;
      hold = kb_data_oe;
      repeat ($urandom_range(0, 3)) tick();
      chk("hold_between", {31'd0, kb_data_oe}, {31'd0, hold});
      kb_negedge = 1'b1;
      tick();
      kb_negedge = 1'b0;
      chk($sformatf("bit%0d", i), {30'd0, kb_clk_oe, kb_data_oe}, {30'd0, 1'b0, ~lv[i]});
    end
    if (mode == 3) begin
      wait_err("bit_to", BITT);
      return;
    end
    if (mode == 4) begin
      #2 reset = 1'b0;
      #1;
      chk("rst_oe", {30'd0, kb_clk_oe, kb_data_oe}, 0);
      chk("rst_busy", {31'd0, tx_busy}, 0);
      tx_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("rst_ready", {31'd0, tx_ready}, 1);
      return;
    end
    repeat ($urandom_range(0, 3)) tick();
    kb_data    = (mode == 0) ? 1'b0 : 1'b1;
    kb_negedge = 1'b1;
    tick();
    kb_negedge = 1'b0;
    kb_data    = 1'b1;
    tx_valid   = 1'b0;
    chk("done", {31'd0, tx_done}, 1);
    chk("ack", {31'd0, tx_ack}, (mode == 0) ? 1 : 0);
    chk("done_oe", {30'd0, kb_clk_oe, kb_data_oe}, 0);
    tick();
    chk("done_pulse", {31'd0, tx_done}, 0);
    chk("ready_end", {31'd0, tx_ready}, 1);
  endtask

  initial begin
    #3;
    chk("rst_oe", {30'd0, kb_clk_oe, kb_data_oe}, 0);
    chk("rst_flags", {29'd0, tx_done, tx_ack, tx_err}, 0);
    chk("rst_busy", {31'd0, tx_busy}, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_ready", {31'd0, tx_ready}, 1);
    tx_valid = 1'b0;
    tick();
    chk("idle_ignores", {31'd0, tx_busy}, 0);

    run_frame(8'hED, 0, 0);
    run_frame(8'h00, 0, 0);
    run_frame(8'h01, 0, 0);
    run_frame(8'hFF, 2, 0);
    run_frame(8'hF4, 3, 5);
    run_frame(8'hAB, 0, 0);
    run_frame(8'h5A, 1, 0);
    run_frame(8'h3C, 4, 4);
    run_frame(8'h77, 0, 0);
    for (int f = 0; f < 25; f++) begin
      int m;
      m = $urandom_range(0, 4);
      run_frame(8'($urandom), m, $urandom_range(1, 10));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
